// File: rtl/cfg_rr_arbiter.sv
// cfg_rr_arbiter: round-robin arbiter sharing one config sink port among N_REQ requesters,
// with a programmable idle turnaround gap after every accepted transfer.
module cfg_rr_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 3,
  parameter int HOLD   = 2,
  parameter int SRC_W  = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ*TAG_W-1:0]  req_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [TAG_W-1:0]        out_tag,
  output logic [SRC_W-1:0]        out_src,
  output logic                    busy
);
  localparam int HW = HOLD > 0 ? $clog2(HOLD + 1) : 1;
  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;
  state_t           r_state, w_next;
  logic [SRC_W-1:0] r_ptr, w_win;
  logic [HW-1:0]    r_hcnt;
  logic             w_found;
  // Scan from the far end back toward ptr so the nearest valid requester wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(r_ptr) + k) % N_REQ]) begin
        w_found = 1'b1;
        w_win   = SRC_W'((int'(r_ptr) + k) % N_REQ);
      end
    end
  end
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && w_found) w_next = GRANT;
    if (r_state == GRANT && out_ready) w_next = HOLD == 0 ? IDLE : TURN;
    if (r_state == TURN && r_hcnt == HW'(1)) w_next = IDLE;
  end
  assign req_ready = (r_state == IDLE && w_found && !rst) ? N_REQ'(1) << w_win : '0;
  assign out_valid = r_state == GRANT;
  assign busy      = r_state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_hcnt   <= '0;
      out_data <= '0;
      out_tag  <= '0;
      out_src  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_found) begin
        out_data <= req_data[w_win*DATA_W +: DATA_W];
        out_tag  <= req_tag[w_win*TAG_W +: TAG_W];
        out_src  <= w_win;
        r_ptr    <= w_win == SRC_W'(N_REQ - 1) ? '0 : w_win + 1'b1;
      end
      if (r_state == GRANT && out_ready) r_hcnt <= HW'(HOLD);
      if (r_state == TURN) r_hcnt <= r_hcnt - 1'b1;
    end
  end
endmodule

// File: tb/tb_cfg_rr_arbiter.sv
// tb_cfg_rr_arbiter: directed and randomized checks of cfg_rr_arbiter against a
// word-level reference model (HOLD=2 main instance, HOLD=0 side instance).
module tb_cfg_rr_arbiter;
  localparam int N = 4, DW = 32, TW = 3, SW = 2, HOLD = 2;
  localparam int VW = N + 2 + SW + TW + DW;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [N-1:0]    req_valid = '0, req_ready, req_valid0 = '0, req_ready0;
  logic [N*DW-1:0] req_data = '0;
  logic [N*TW-1:0] req_tag = '0;
  logic            out_valid, out_ready = 1'b0, busy;
  logic            out_valid0, out_ready0 = 1'b0, busy0;
  logic [DW-1:0]   out_data, out_data0;
  logic [TW-1:0]   out_tag, out_tag0;
  logic [SW-1:0]   out_src, out_src0;
  int vectors = 0, errors = 0;

  cfg_rr_arbiter #(.N_REQ(N), .DATA_W(DW), .TAG_W(TW), .HOLD(HOLD)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_tag(req_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .out_src(out_src), .busy(busy));
  cfg_rr_arbiter #(.N_REQ(N), .DATA_W(DW), .TAG_W(TW), .HOLD(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_data(req_data), .req_tag(req_tag), .out_valid(out_valid0), .out_ready(out_ready0),
    .out_data(out_data0), .out_tag(out_tag0), .out_src(out_src0), .busy(busy0));

  // Reference model: a word is either on the bus, or the bus waits m_gap idle cycles.
  int          m_ptr = 0, m_gap = 0, m_src = 0, m_w;
  bit          m_on = 1'b0;
  logic [DW-1:0] m_data = '0;
  logic [TW-1:0] m_tag = '0;
  function automatic int pick(int p, logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction
  function automatic int oh(logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction
  always @(posedge clk) begin
    m_w = pick(m_ptr, req_valid);
    if (rst) begin
      m_ptr = 0; m_gap = 0; m_on = 0; m_src = 0; m_data = '0; m_tag = '0;
    end else if (!m_on && m_gap == 0) begin
      if (m_w >= 0) begin
        m_on = 1; m_src = m_w; m_ptr = (m_w + 1) % N;
        m_data = req_data[m_w*DW +: DW];
        m_tag = req_tag[m_w*TW +: TW];
      end
    end else if (m_on) begin
      if (out_ready) begin m_on = 0; m_gap = HOLD; end
    end else m_gap = m_gap - 1;
  end
  function automatic logic [VW-1:0] expv();
    int w = pick(m_ptr, req_valid);
    bit idle = !m_on && m_gap == 0;
    logic [N-1:0] r = (idle && !rst && w >= 0) ? N'(1) << w : '0;
    return {r, m_on, !idle, SW'(m_src), m_tag, m_data};
  endfunction
  function automatic logic [VW-1:0] dutv();
    return {req_ready, out_valid, busy, out_src, out_tag, out_data};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic reset_dut();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if (req_ready !== '0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold c%0d ready=%b valid=%b need 0000/0", c, req_ready, out_valid);
      end
      vectors++;
      if (dutv() !== expv()) begin
        errors++;
        $display("FAIL reset_model c%0d got=%h exp=%h", c, dutv(), expv());
      end
      tick();
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL reset_first_grant ready=%b need 0001", req_ready);
    end
    tick();
  endtask

  task automatic test_round_robin();
    int srcs[$], cycs[$];
    int exp_c[5] = '{0, 4, 8, 12, 16};
    int exp_s[5] = '{0, 1, 2, 3, 0};
    for (int i = 0; i < N; i++) begin
      req_data[i*DW +: DW] = 32'hA0 + i;
      req_tag[i*TW +: TW] = TW'(i);
    end
    req_valid = '1;
    out_ready = 1'b1;
    reset_dut();
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      vectors++;
      if (dutv() !== expv()) begin
        errors++;
        $display("FAIL rr_model c%0d got=%h exp=%h", c, dutv(), expv());
      end
      if (req_ready != 0) begin srcs.push_back(oh(req_ready)); cycs.push_back(c); end
      tick();
    end
    vectors++;
    if (srcs.size() != 5) begin
      errors++;
      $display("FAIL rr_count got=%0d need 5", srcs.size());
    end else
      for (int i = 0; i < 5; i++) begin
        vectors++;
        if (srcs[i] != exp_s[i] || cycs[i] != exp_c[i]) begin
          errors++;
          $display("FAIL rr_order #%0d src=%0d@%0d need %0d@%0d", i, srcs[i], cycs[i], exp_s[i], exp_c[i]);
        end
      end
  endtask

  task automatic test_sparse();
    int srcs[$], tags[$];
    int exp_s[3] = '{1, 3, 1};
    int exp_t[3] = '{2, 5, 2};
    logic [N-1:0] nv;
    bit cap = 0;
    req_tag = '0;
    req_tag[3*TW +: TW] = 3'h5;
    req_tag[1*TW +: TW] = 3'h2;
    req_valid = 4'b0010;
    out_ready = 1'b1;
    reset_dut();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      vectors++;
      if (dutv() !== expv()) begin
        errors++;
        $display("FAIL sparse_model c%0d got=%h exp=%h", c, dutv(), expv());
      end
      if (cap) tags.push_back(int'(out_tag));
      cap = req_ready != 0;
      nv = req_valid & ~req_ready;
      if (req_ready != 0) srcs.push_back(oh(req_ready));
      if (c == 0) nv |= 4'b1010;
      tick();
      req_valid = nv;
    end
    vectors++;
    if (srcs.size() != 3 || tags.size() != 3) begin
      errors++;
      $display("FAIL sparse_count grants=%0d tags=%0d need 3/3", srcs.size(), tags.size());
    end else
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (srcs[i] != exp_s[i] || tags[i] != exp_t[i]) begin
          errors++;
          $display("FAIL sparse_grant #%0d src=%0d tag=%0d need %0d/%0d", i, srcs[i], tags[i], exp_s[i], exp_t[i]);
        end
      end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] d = 32'h1234_5678;
    req_data[2*DW +: DW] = d;
    req_valid = 4'b0100;
    out_ready = 1'b0;
    reset_dut();
    @(negedge clk);
    vectors++;
    if (dutv() !== expv()) begin
      errors++;
      $display("FAIL bp_capture got=%h exp=%h", dutv(), expv());
    end
    tick();
    req_valid = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || out_data !== d || out_src !== 2'd2 || req_ready !== '0) begin
        errors++;
        $display("FAIL bp_hold c%0d valid=%b data=%h src=%0d ready=%b need 1/%h/2/0000", c, out_valid, out_data, out_src, req_ready, d);
      end
      tick();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== (k == 0) || busy !== (k < 3)) begin
        errors++;
        $display("FAIL bp_release k%0d valid=%b busy=%b need %b/%b", k, out_valid, busy, k == 0, k < 3);
      end
      vectors++;
      if (dutv() !== expv()) begin
        errors++;
        $display("FAIL bp_model k%0d got=%h exp=%h", k, dutv(), expv());
      end
      tick();
    end
  endtask

  task automatic test_hold0();
    req_valid = '0;
    out_ready = 1'b0;
    req_valid0 = 4'b0100;
    out_ready0 = 1'b1;
    reset_dut();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      vectors++;
      if (busy0 !== k[0] || out_valid0 !== k[0] || req_ready0 !== (k[0] ? 4'b0000 : 4'b0100)) begin
        errors++;
        $display("FAIL hold0 k%0d busy=%b valid=%b ready=%b need %b/%b/%b", k, busy0, out_valid0, req_ready0, k[0], k[0], k[0] ? 4'b0000 : 4'b0100);
      end
      if (k[0]) begin
        vectors++;
        if (out_src0 !== 2'd2) begin
          errors++;
          $display("FAIL hold0_src k%0d src=%0d need 2", k, out_src0);
        end
      end
      tick();
    end
    req_valid0 = '0;
    out_ready0 = 1'b0;
  endtask

  task automatic test_reset_grant();
    req_data[2*DW +: DW] = 32'hDEADBEEF;
    req_data[3*DW +: DW] = 32'h3333_3333;
    req_valid = 4'b1100;
    out_ready = 1'b0;
    reset_dut();
    @(negedge clk);
    vectors++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL rg_first ready=%b need 0100", req_ready);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rg_grant valid=%b data=%h need 1/deadbeef", out_valid, out_data);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || out_data !== '0 || req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL rg_after valid=%b data=%h ready=%b need 0/0/0100", out_valid, out_data, req_ready);
    end
    vectors++;
    if (dutv() !== expv()) begin
      errors++;
      $display("FAIL rg_model got=%h exp=%h", dutv(), expv());
    end
    tick();
  endtask

  task automatic test_random();
    reset_dut();
    for (int c = 0; c < 400; c++) begin
      req_valid = N'($urandom);
      req_data = {$urandom, $urandom, $urandom, $urandom};
      req_tag = (N*TW)'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      rst = $urandom_range(0, 49) == 0;
      @(negedge clk);
      vectors++;
      if (dutv() !== expv()) begin
        errors++;
        $display("FAIL random c%0d got=%h exp=%h", c, dutv(), expv());
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    tick();
    test_reset();
    test_round_robin();
    test_sparse();
    test_backpressure();
    test_hold0();
    test_reset_grant();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
